// File: rtl/counter_ctrl.sv
// counter_ctrl: command sequencer that drives a counter's load/enable/data_in.
// LOAD, RUN-for-N and FREE-RUN commands arrive over a valid/ready port and
// become cycle-exact load/enable pulse trains; done pulses once per finished
// or aborted command.
// Optional feature macro: COUNTER_CTRL_QUEUE_EN adds a one-entry pending
// command register so back-to-back commands run without an idle bubble.
//
// Handshake: a command is taken on the rising edge where cmd_valid && cmd_ready
// are both high; cmd_valid may be held across cycles until that edge, and the
// command fields must be stable while cmd_valid is high.
module counter_ctrl #(
  parameter int IDATA_WIDTH = 16,
  parameter int RUN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [IDATA_WIDTH-1:0] cmd_data,
  input  logic                   abort,
  output logic                   load,
  output logic                   enable,
  output logic [IDATA_WIDTH-1:0] data_in,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FREE = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_FREE = 2'b11;

  localparam logic [RUN_WIDTH-1:0] RUN_ONE = RUN_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [RUN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [IDATA_WIDTH-1:0] data_in_q, data_in_d;
  logic                   load_q, load_d;
  logic                   enable_q, enable_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Command to launch on this edge (from the port or from the pending slot)
  logic                   nxt_valid;
  logic [1:0]             nxt_op;
  logic [IDATA_WIDTH-1:0] nxt_data;
  logic                   cmd_fire;

`ifdef COUNTER_CTRL_QUEUE_EN
  logic                   pend_valid_q, pend_valid_d;
  logic [1:0]             pend_op_q, pend_op_d;
  logic [IDATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic                   cmd_end;

  // Ready while the pending slot is free; an effective abort blocks new commands
  always_comb begin
    cmd_ready = !pend_valid_q &&
                !(abort && (state_q == S_RUN || state_q == S_FREE));
  end
`else
  // Without a pending slot a command can only be taken from IDLE
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
  end
`endif

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign load      = load_q;
  assign enable    = enable_q;
  assign data_in   = data_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    data_in_d   = data_in_q;
    done_d      = 1'b0;
    nxt_valid   = 1'b0;
    nxt_op      = OP_NOP;
    nxt_data    = '0;
`ifdef COUNTER_CTRL_QUEUE_EN
    pend_valid_d = pend_valid_q;
    pend_op_d    = pend_op_q;
    pend_data_d  = pend_data_q;
    cmd_end      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // abort is meaningless here, so a command is taken regardless
        if (cmd_fire) begin
          nxt_valid = 1'b1;
          nxt_op    = cmd_op;
          nxt_data  = cmd_data;
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
`ifdef COUNTER_CTRL_QUEUE_EN
        cmd_end = 1'b1;
`endif
      end
      S_RUN: begin
        if (abort) begin
          state_d     = S_IDLE;
          remaining_d = '0;
          done_d      = 1'b1;
`ifdef COUNTER_CTRL_QUEUE_EN
          pend_valid_d = 1'b0;
`endif
        end else if (remaining_q == RUN_ONE) begin
          state_d     = S_IDLE;
          remaining_d = '0;
          done_d      = 1'b1;
`ifdef COUNTER_CTRL_QUEUE_EN
          cmd_end = 1'b1;
`endif
        end else begin
          remaining_d = remaining_q - RUN_ONE;
        end
      end
      S_FREE: begin
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
`ifdef COUNTER_CTRL_QUEUE_EN
          pend_valid_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef COUNTER_CTRL_QUEUE_EN
    // At the end of a command, chain straight into the pending (or arriving) one
    if (cmd_end) begin
      if (pend_valid_q) begin
        nxt_valid    = 1'b1;
        nxt_op       = pend_op_q;
        nxt_data     = pend_data_q;
        pend_valid_d = 1'b0;
      end else if (cmd_fire) begin
        nxt_valid = 1'b1;
        nxt_op    = cmd_op;
        nxt_data  = cmd_data;
      end
    end else if (state_q != S_IDLE && cmd_fire && cmd_op != OP_NOP) begin
      pend_valid_d = 1'b1;
      pend_op_d    = cmd_op;
      pend_data_d  = cmd_data;
    end
`endif

    if (nxt_valid) begin
      case (nxt_op)
        OP_LOAD: begin
          state_d   = S_LOAD;
          data_in_d = nxt_data;
        end
        OP_RUN: begin
          if (nxt_data[RUN_WIDTH-1:0] != '0) begin
            state_d     = S_RUN;
            remaining_d = nxt_data[RUN_WIDTH-1:0];
          end else begin
            done_d = 1'b1;
          end
        end
        OP_FREE: state_d = S_FREE;
        default: ;
      endcase
    end

    load_d   = (state_d == S_LOAD);
    enable_d = (state_d == S_RUN) || (state_d == S_FREE);
`ifdef COUNTER_CTRL_QUEUE_EN
    busy_d   = (state_d != S_IDLE) || pend_valid_d;
`else
    busy_d   = (state_d != S_IDLE);
`endif
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      data_in_q   <= '0;
      load_q      <= 1'b0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_in_q   <= data_in_d;
      load_q      <= load_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef COUNTER_CTRL_QUEUE_EN
  // Pending command slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_q <= 1'b0;
      pend_op_q    <= OP_NOP;
      pend_data_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_op_q    <= pend_op_d;
      pend_data_q  <= pend_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Testbench for counter_ctrl (default build): directed command vectors with
// hand-computed per-cycle expectations pushed to a queue, popped by a monitor.
module tb_counter_ctrl;

  localparam int W  = 16;
  localparam int EW = 5 + W;  // {cmd_ready, load, enable, busy, done, data_in}

  logic         clk;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         abort;
  logic         load;
  logic         enable;
  logic [W-1:0] data_in;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  logic [EW-1:0] exp_q[$];
  int vectors;
  int miscompares;
  int cycle_no;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] LD   = 2'b01;
  localparam logic [1:0] RUN  = 2'b10;
  localparam logic [1:0] FREE = 2'b11;

  counter_ctrl #(.IDATA_WIDTH(W), .RUN_WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .load      (load),
    .enable    (enable),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Direct check used around the asynchronous reset
  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One cycle: record the outputs expected for this cycle, then drive the
  // inputs that will be sampled at the next rising edge.
  task automatic cyc(input logic rdy, input logic ld, input logic en, input logic bsy,
                     input logic dn, input logic [W-1:0] di,
                     input logic v, input logic [1:0] op, input logic [W-1:0] d,
                     input logic ab);
    @(posedge clk);
    #1;
    exp_q.push_back({rdy, ld, en, bsy, dn, di});
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    abort     = ab;
  endtask

  // Scoreboard monitor: compares every cycle that has an expectation queued
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] g;
    if (reset_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {cmd_ready, load, enable, busy, done, data_in};
      cycle_no++;
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL cycle_%0d {rdy,ld,en,busy,done,data}: got %b_%b_%b_%b_%b_%h expected %b_%b_%b_%b_%b_%h",
                 cycle_no, g[EW-1], g[EW-2], g[EW-3], g[EW-4], g[EW-5], g[W-1:0],
                 e[EW-1], e[EW-2], e[EW-3], e[EW-4], e[EW-5], e[W-1:0]);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycle_no    = 0;
    reset_n     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = NOP;
    cmd_data    = '0;
    abort       = 1'b0;

    // Reset state
    #2;
    chk("reset_outputs", {11'b0, load, enable, busy, done, 1'b0}, 16'h0);
    chk("reset_data_in", data_in, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;

    //   rdy ld en bsy dn data      | v  op    data     abort
    cyc(1, 0, 0, 0, 0, 16'h0000,    1, LD,   16'h1234, 0);
    cyc(0, 1, 0, 1, 0, 16'h1234,    0, NOP,  16'h0000, 0);
    cyc(1, 0, 0, 0, 1, 16'h1234,    0, NOP,  16'h0000, 0);
    cyc(1, 0, 0, 0, 0, 16'h1234,    1, RUN,  16'h0005, 0);
    repeat (5) cyc(0, 0, 1, 1, 0, 16'h1234, 0, NOP, 16'h0000, 0);
    cyc(1, 0, 0, 0, 1, 16'h1234,    0, NOP,  16'h0000, 0);
    // RUN 0: done next cycle with no enable
    cyc(1, 0, 0, 0, 0, 16'h1234,    1, RUN,  16'h0000, 0);
    cyc(1, 0, 0, 0, 1, 16'h1234,    0, NOP,  16'h0000, 0);
    // FREE, abort with a simultaneous command after 10 enabled cycles
    cyc(1, 0, 0, 0, 0, 16'h1234,    1, FREE, 16'h0000, 0);
    repeat (9) cyc(0, 0, 1, 1, 0, 16'h1234, 0, NOP, 16'h0000, 0);
    cyc(0, 0, 1, 1, 0, 16'h1234,    1, LD,   16'hBEEF, 1);
    cyc(1, 0, 0, 0, 1, 16'h1234,    0, NOP,  16'h0000, 0);
    // LOAD 7 then RUN 3 held valid: RUN taken in LOAD's done cycle
    cyc(1, 0, 0, 0, 0, 16'h1234,    1, LD,   16'h0007, 0);
    cyc(0, 1, 0, 1, 0, 16'h0007,    1, RUN,  16'h0003, 0);
    cyc(1, 0, 0, 0, 1, 16'h0007,    1, RUN,  16'h0003, 0);
    cyc(0, 0, 1, 1, 0, 16'h0007,    0, NOP,  16'h0000, 0);
    repeat (2) cyc(0, 0, 1, 1, 0, 16'h0007, 0, NOP, 16'h0000, 0);
    cyc(1, 0, 0, 0, 1, 16'h0007,    0, NOP,  16'h0000, 0);
    // abort while idle is ignored; the RUN 2 beside it is taken
    cyc(1, 0, 0, 0, 0, 16'h0007,    1, RUN,  16'h0002, 1);
    cyc(0, 0, 1, 1, 0, 16'h0007,    0, NOP,  16'h0000, 0);
    cyc(0, 0, 1, 1, 0, 16'h0007,    0, NOP,  16'h0000, 0);
    cyc(1, 0, 0, 0, 1, 16'h0007,    0, NOP,  16'h0000, 0);
    // abort in the middle of RUN 4
    cyc(1, 0, 0, 0, 0, 16'h0007,    1, RUN,  16'h0004, 0);
    cyc(0, 0, 1, 1, 0, 16'h0007,    0, NOP,  16'h0000, 0);
    cyc(0, 0, 1, 1, 0, 16'h0007,    0, NOP,  16'h0000, 1);
    cyc(1, 0, 0, 0, 1, 16'h0007,    0, NOP,  16'h0000, 0);
    cyc(1, 0, 0, 0, 0, 16'h0007,    0, NOP,  16'h0000, 0);
    // NOP is accepted silently
    cyc(1, 0, 0, 0, 0, 16'h0007,    1, NOP,  16'hFFFF, 0);
    cyc(1, 0, 0, 0, 0, 16'h0007,    1, FREE, 16'h0000, 0);
    cyc(0, 0, 1, 1, 0, 16'h0007,    0, NOP,  16'h0000, 0);
    cyc(0, 0, 1, 1, 0, 16'h0007,    0, NOP,  16'h0000, 0);

    // Asynchronous reset in the middle of FREE
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_enable", {15'b0, enable}, 16'h0);
    chk("async_load",   {15'b0, load},   16'h0);
    chk("async_done",   {15'b0, done},   16'h0);
    chk("async_busy",   {15'b0, busy},   16'h0);
    chk("async_data",   data_in,         16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = NOP;

    // After release: ready, data cleared, and a fresh LOAD works
    cyc(1, 0, 0, 0, 0, 16'h0000,    1, LD,   16'hA5A5, 0);
    cyc(0, 1, 0, 1, 0, 16'hA5A5,    0, NOP,  16'h0000, 0);
    cyc(1, 0, 0, 0, 1, 16'hA5A5,    0, NOP,  16'h0000, 0);
    cyc(1, 0, 0, 0, 0, 16'hA5A5,    0, NOP,  16'h0000, 0);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
